// File: rtl/rib_master_arbiter.sv
// rib_master_arbiter: shares one rib request/response channel among
// MASTER_NUM masters. One outstanding transaction at a time; the grant is
// held from arbitration until the response handshake completes.
// Optional macro RIB_ARB_RR_EN selects round-robin arbitration instead of
// fixed highest-index-wins priority.
module rib_master_arbiter #(
  parameter int MASTER_NUM = 3,
  parameter int IDX_W      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [MASTER_NUM*32-1:0]   m_addr_i,
  input  logic [MASTER_NUM*32-1:0]   m_data_i,
  input  logic [MASTER_NUM*4-1:0]    m_sel_i,
  input  logic [MASTER_NUM-1:0]      m_we_i,
  input  logic [MASTER_NUM-1:0]      m_req_vld_i,
  output logic [MASTER_NUM-1:0]      m_req_rdy_o,
  input  logic [MASTER_NUM-1:0]      m_rsp_rdy_i,
  output logic [MASTER_NUM-1:0]      m_rsp_vld_o,
  output logic [31:0]                m_data_o,
  output logic [31:0]                s_addr_o,
  output logic [31:0]                s_data_o,
  output logic [3:0]                 s_sel_o,
  output logic                       s_we_o,
  output logic                       s_req_vld_o,
  input  logic                       s_req_rdy_i,
  input  logic                       s_rsp_vld_i,
  output logic                       s_rsp_rdy_o,
  input  logic [31:0]                s_data_i,
  output logic [MASTER_NUM-1:0]      grant_o,
  output logic                       busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]       win;

  logic [31:0]            sel_addr, sel_data;
  logic [3:0]             sel_sel;
  logic                   sel_we, sel_vld, sel_rsp_rdy;
  logic [MASTER_NUM-1:0]  gnt_oh;

`ifdef RIB_ARB_RR_EN
  logic [IDX_W-1:0]       ptr_q;

  // Round-robin: first requester strictly above the last-served index,
  // otherwise the lowest-index requester (wrap-around).
  function automatic logic [IDX_W-1:0] pick_rr(input logic [MASTER_NUM-1:0] req,
                                               input logic [IDX_W-1:0]      ptr);
    logic [IDX_W-1:0] w_hi, w_lo;
    logic             found_hi;
    w_hi     = '0;
    w_lo     = '0;
    found_hi = 1'b0;
    for (int k = MASTER_NUM - 1; k >= 0; k--) begin
      if (req[k]) begin
        if (IDX_W'(k) > ptr) begin
          w_hi     = IDX_W'(k);
          found_hi = 1'b1;
        end else begin
          w_lo = IDX_W'(k);
        end
      end
    end
    return found_hi ? w_hi : w_lo;
  endfunction

  assign win = pick_rr(m_req_vld_i, ptr_q);

  // Last-served pointer advances only when a response completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(MASTER_NUM - 1);
    end else if (state_q == RSP && s_rsp_vld_i && sel_rsp_rdy) begin
      ptr_q <= gnt_q;
    end
  end
`else
  // Fixed priority: the highest requesting index wins.
  function automatic logic [IDX_W-1:0] pick_fixed(input logic [MASTER_NUM-1:0] req);
    logic [IDX_W-1:0] w;
    w = '0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      if (req[k]) w = IDX_W'(k);
    end
    return w;
  endfunction

  assign win = pick_fixed(m_req_vld_i);
`endif

  // Select the granted master's payload and handshake bits.
  always_comb begin
    sel_addr    = '0;
    sel_data    = '0;
    sel_sel     = '0;
    sel_we      = 1'b0;
    sel_vld     = 1'b0;
    sel_rsp_rdy = 1'b0;
    gnt_oh      = '0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      if (gnt_q == IDX_W'(k)) begin
        sel_addr    = m_addr_i[32*k +: 32];
        sel_data    = m_data_i[32*k +: 32];
        sel_sel     = m_sel_i[4*k +: 4];
        sel_we      = m_we_i[k];
        sel_vld     = m_req_vld_i[k];
        sel_rsp_rdy = m_rsp_rdy_i[k];
        gnt_oh[k]   = 1'b1;
      end
    end
  end

  // State and grant index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state and output decode; everything inactive outside the active phase.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    m_req_rdy_o = '0;
    m_rsp_vld_o = '0;
    m_data_o    = '0;
    s_addr_o    = '0;
    s_data_o    = '0;
    s_sel_o     = '0;
    s_we_o      = 1'b0;
    s_req_vld_o = 1'b0;
    s_rsp_rdy_o = 1'b0;
    grant_o     = '0;
    busy_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|m_req_vld_i) begin
          gnt_d   = win;
          state_d = REQ;
        end
      end
      REQ: begin
        busy_o      = 1'b1;
        grant_o     = gnt_oh;
        s_addr_o    = sel_addr;
        s_data_o    = sel_data;
        s_sel_o     = sel_sel;
        s_we_o      = sel_we;
        s_req_vld_o = sel_vld;
        m_req_rdy_o = gnt_oh & {MASTER_NUM{s_req_rdy_i}};
        if (sel_vld && s_req_rdy_i) state_d = RSP;
      end
      RSP: begin
        busy_o      = 1'b1;
        grant_o     = gnt_oh;
        s_addr_o    = sel_addr;
        s_data_o    = sel_data;
        s_sel_o     = sel_sel;
        s_we_o      = sel_we;
        s_rsp_rdy_o = sel_rsp_rdy;
        m_rsp_vld_o = gnt_oh & {MASTER_NUM{s_rsp_vld_i}};
        m_data_o    = s_data_i;
        if (s_rsp_vld_i && sel_rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rib_master_arbiter.sv
// Randomized bench for rib_master_arbiter with a transaction-level
// reference model (granted master, accepted flag, arbitration by rule).
module tb_rib_master_arbiter;
  localparam int N = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*32-1:0]   m_addr_i, m_data_i;
  logic [N*4-1:0]    m_sel_i;
  logic [N-1:0]      m_we_i, m_req_vld_i, m_req_rdy_o, m_rsp_rdy_i, m_rsp_vld_o;
  logic [31:0]       m_data_o, s_addr_o, s_data_o, s_data_i;
  logic [3:0]        s_sel_o;
  logic              s_we_o, s_req_vld_o, s_req_rdy_i, s_rsp_vld_i, s_rsp_rdy_o;
  logic [N-1:0]      grant_o;
  logic              busy_o;

  rib_master_arbiter #(.MASTER_NUM(N), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_req_vld_i(m_req_vld_i), .m_req_rdy_o(m_req_rdy_o),
    .m_rsp_rdy_i(m_rsp_rdy_i), .m_rsp_vld_o(m_rsp_vld_o), .m_data_o(m_data_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_req_vld_o(s_req_vld_o), .s_req_rdy_i(s_req_rdy_i),
    .s_rsp_vld_i(s_rsp_vld_i), .s_rsp_rdy_o(s_rsp_rdy_o), .s_data_i(s_data_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state: which master owns the channel (-1 = none),
  // whether its request was accepted, and the last-served master.
  int        cur;
  bit        acc;
  int        ptr;
  int        done_cnt;
  bit [31:0] ma [N];
  bit [31:0] md [N];
  bit [3:0]  ms [N];
  bit        mw [N];
  bit        mv [N];

  function automatic int ref_pick();
`ifdef RIB_ARB_RR_EN
    for (int off = 1; off <= N; off++) begin
      if (mv[(ptr + off) % N]) return (ptr + off) % N;
    end
`else
    for (int k = N - 1; k >= 0; k--) begin
      if (mv[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic drive_masters();
    for (int k = 0; k < N; k++) begin
      m_addr_i[32*k +: 32] = ma[k];
      m_data_i[32*k +: 32] = md[k];
      m_sel_i[4*k +: 4]    = ms[k];
      m_we_i[k]            = mw[k];
      m_req_vld_i[k]       = mv[k];
    end
  endtask

  task automatic new_req(input int k);
    ma[k] = $urandom;
    md[k] = $urandom;
    ms[k] = 4'($urandom_range(0, 15));
    mw[k] = 1'($urandom_range(0, 1));
    mv[k] = 1'b1;
  endtask

  task automatic check_outputs();
    logic [N-1:0] oh, e_grant, e_rrdy, e_rvld;
    logic [31:0]  e_addr, e_data;
    logic [3:0]   e_sel;
    logic         e_we, e_svld, e_srdy;
    oh = '0; e_grant = '0; e_rrdy = '0; e_rvld = '0;
    e_addr = '0; e_data = '0; e_sel = '0; e_we = 1'b0; e_svld = 1'b0; e_srdy = 1'b0;
    if (cur >= 0) begin
      oh      = N'(1) << cur;
      e_grant = oh;
      e_addr  = ma[cur];
      e_data  = md[cur];
      e_sel   = ms[cur];
      e_we    = mw[cur];
      if (!acc) begin
        e_svld = mv[cur];
        e_rrdy = s_req_rdy_i ? oh : '0;
      end else begin
        e_rvld = s_rsp_vld_i ? oh : '0;
        e_srdy = m_rsp_rdy_i[cur];
      end
    end
    check_val("grant",     64'(grant_o),     64'(e_grant));
    check_val("busy",      64'(busy_o),      64'(cur >= 0));
    check_val("s_addr",    64'(s_addr_o),    64'(e_addr));
    check_val("s_data",    64'(s_data_o),    64'(e_data));
    check_val("s_sel",     64'(s_sel_o),     64'(e_sel));
    check_val("s_we",      64'(s_we_o),      64'(e_we));
    check_val("s_req_vld", 64'(s_req_vld_o), 64'(e_svld));
    check_val("m_req_rdy", 64'(m_req_rdy_o), 64'(e_rrdy));
    check_val("m_rsp_vld", 64'(m_rsp_vld_o), 64'(e_rvld));
    check_val("s_rsp_rdy", 64'(s_rsp_rdy_o), 64'(e_srdy));
    if (cur >= 0 && acc) check_val("m_data", 64'(m_data_o), 64'(s_data_i));
  endtask

  // Advance the model across one clock edge using the pre-edge inputs.
  task automatic model_step();
    int w;
    if (cur < 0) begin
      w = ref_pick();
      if (w >= 0) begin
        cur = w;
        acc = 1'b0;
      end
    end else if (!acc) begin
      if (mv[cur] && s_req_rdy_i) begin
        acc     = 1'b1;
        mv[cur] = 1'b0;
      end
    end else if (s_rsp_vld_i && m_rsp_rdy_i[cur]) begin
      ptr = cur;
      cur = -1;
      done_cnt++;
    end
  endtask

  initial begin
    bit in_rst, rst_done;
    cur = -1; acc = 1'b0; ptr = N - 1; done_cnt = 0;
    in_rst = 1'b0; rst_done = 1'b0;
    for (int k = 0; k < N; k++) begin
      ma[k] = '0; md[k] = '0; ms[k] = '0; mw[k] = 1'b0; mv[k] = 1'b0;
    end
    rst_n = 1'b0;
    m_addr_i = '0; m_data_i = '0; m_sel_i = '0; m_we_i = '0; m_req_vld_i = '0;
    m_rsp_rdy_i = '0; s_req_rdy_i = 1'b0; s_rsp_vld_i = 1'b0; s_data_i = '0;

    // All masters raise a request while reset is still asserted.
    repeat (2) @(posedge clk);
    #1;
    new_req(0); new_req(1); new_req(2);
    ma[2] = 32'h2000_0004; md[2] = 32'h1234_5678; ms[2] = 4'hF; mw[2] = 1'b1;
    ma[0] = 32'h0000_0100; mw[0] = 1'b0;
    drive_masters();
    #3 check_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    #3 check_outputs();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      if (in_rst) begin
        #1 rst_n = 1'b1;
        in_rst = 1'b0;
      end else begin
        model_step();
        #1;
        if (!rst_done && cyc > 1500 && cur >= 0 && acc) begin
          rst_n    = 1'b0;
          in_rst   = 1'b1;
          rst_done = 1'b1;
          cur = -1; acc = 1'b0; ptr = N - 1;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (!mv[k] && $urandom_range(0, 3) == 0) new_req(k);
      end
      drive_masters();
      s_req_rdy_i = 1'($urandom_range(0, 1));
      s_rsp_vld_i = 1'($urandom_range(0, 1));
      s_data_i    = $urandom;
      m_rsp_rdy_i = N'($urandom_range(0, 7));
      #3 check_outputs();
    end

    check_val("progress", 64'(done_cnt > 100), 64'(1));
    check_val("reset_hit", 64'(rst_done), 64'(1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
